// File: rtl/dff_deser_pkg.sv
// dff_deser shared definitions: collect-FSM encodings and counter sizing.
// Optional build macro: DFF_DESER_PARITY_EN (adds a trailing even-parity bit).
package dff_deser_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t PARITY = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/dff_deser_if.sv
// dff_deser serial-in / word-out bundle.
// Optional build macro: DFF_DESER_PARITY_EN (adds parity_err).
interface dff_deser_if #(
  parameter int WIDTH = 8
);

  logic             bit_valid;
  logic             bit_in;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             overrun;
  logic             busy;
`ifdef DFF_DESER_PARITY_EN
  logic             parity_err;

  modport master (
    output bit_valid, bit_in, word_ready,
    input  word_out, word_valid, overrun, busy, parity_err
  );

  modport slave (
    input  bit_valid, bit_in, word_ready,
    output word_out, word_valid, overrun, busy, parity_err
  );
`else
  modport master (
    output bit_valid, bit_in, word_ready,
    input  word_out, word_valid, overrun, busy
  );

  modport slave (
    input  bit_valid, bit_in, word_ready,
    output word_out, word_valid, overrun, busy
  );
`endif

endinterface

// File: rtl/dff_deser_shift.sv
// dff_deser shift register, bit counter and word-done pulse.
// word presents the word including the bit being shifted this cycle.
module dff_deser_shift
  import dff_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_nxt;
  logic [CW-1:0]    cnt;

  // next shift value, direction chosen by MSB_FIRST
  always_comb begin
    if (MSB_FIRST)
      data_nxt = {data[WIDTH-2:0], din};
    else
      data_nxt = {din, data[WIDTH-1:1]};
  end

  assign done = en && (cnt == LAST);
  assign word = en ? data_nxt : data;

  // shift and count on each qualified bit; counter clears at word end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (en) begin
      data <= data_nxt;
      cnt  <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dff_deser.sv
// dff_deser top: collect FSM, holding register, handshake and flags.
// Optional build macro: DFF_DESER_PARITY_EN (trailing even-parity bit).
module dff_deser
  import dff_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  dff_deser_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic             shift_en;
  logic             complete;
  logic             done;
  logic             load;
  logic [WIDTH-1:0] word;

  dff_deser_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk  (clk),
    .clr  (clr),
    .en   (shift_en),
    .din  (bus.bit_in),
    .word (word),
    .done (done)
  );

  // collect-state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next state, shift enable and word-complete strobe
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.bit_valid) begin
          shift_en  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_valid) begin
          shift_en = 1'b1;
          if (done) begin
`ifdef DFF_DESER_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            complete  = 1'b1;
`endif
          end
        end
      end
`ifdef DFF_DESER_PARITY_EN
      PARITY: begin
        if (bus.bit_valid) begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign load     = complete && (!bus.word_valid || bus.word_ready);
  assign bus.busy = (state != IDLE);

  // holding register, handshake and sticky overrun
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus.word_out   <= '0;
      bus.word_valid <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef DFF_DESER_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      if (load) begin
        bus.word_out   <= word;
        bus.word_valid <= 1'b1;
`ifdef DFF_DESER_PARITY_EN
        bus.parity_err <= (^word) ^ bus.bit_in;
`endif
      end else if (bus.word_valid && bus.word_ready) begin
        bus.word_valid <= 1'b0;
      end
      if (complete && !load)
        bus.overrun <= 1'b1;
    end
  end

endmodule

// File: doc/dff_deser.md
# dff_deser

Serial-to-parallel capture block that sits on the receive side of the single-bit D-line stimulus interface exercised by our flip-flop benches. It samples one qualified bit per clock into a shift register built from clearable D flops. It assembles WIDTH-bit words and presents each word on a valid/ready output handshake. A single holding register decouples word assembly from the consumer, and words that arrive while the holding register is full are flagged.

## Interface
- WIDTH, default 8: data bits per word, minimum 2.
- MSB_FIRST, default 1: 1 means the first sampled bit lands in word_out[WIDTH-1]; 0 means it lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset; asynchronous, active-low.
- bit_valid  input  1  bit_in is sampled on this edge.
- bit_in  input  1  serial data bit.
- word_out  output  WIDTH  assembled word in the holding register.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid is also 1.
- overrun  output  1  sticky flag: a completed word was dropped.
- busy  output  1  one or more bits of the current word have been collected.
- parity_err  output  1  present only with DFF_DESER_PARITY_EN.

## Operation
- Collect FSM states:
  - IDLE to SHIFT on the first bit_valid.
  - SHIFT back to IDLE when bit count reaches WIDTH.
  - With parity enabled: SHIFT goes to PARITY at WIDTH bits, and PARITY goes to IDLE on the next bit_valid.
- Bit counter is ceil(log2(WIDTH+1)) bits wide.
  - Increments only on bit_valid.
  - Clears to 0 when a word completes.
  - No wrap-around past WIDTH.
- bit_valid low: shift register, counter and state all hold. Gaps of any length are legal.
- Word completion:
  - Holding register empty, or emptied in the same cycle (word_valid & word_ready): the word is loaded and word_valid is 1.
  - Holding register full and not being consumed: the new word is dropped, word_out is unchanged, overrun is set to 1.
- overrun is cleared only by clr.
- Handshake:
  - word_valid & word_ready on an edge consumes the word. word_valid falls unless a new word loads on that same edge.
  - word_out is stable while word_valid is 1 and no transfer occurs.
- Collection of the next word continues while the holding register is full.
- Reset values: word_out 0, word_valid 0, overrun 0, busy 0, parity_err 0, counter 0, state IDLE.
- clr asserted mid-word discards the partial word and the held word. It takes effect immediately, with no clock needed.

## Timing
- Each bit is sampled on the rising clk edge where bit_valid is 1.
- word_valid and word_out update on the same edge that samples the final bit (the final data bit, or the parity bit when parity is enabled). There are no extra cycles of latency.
- Full throughput is one word per WIDTH consecutive bit_valid cycles (WIDTH+1 with parity), provided word_ready is held at 1.
- busy goes to 1 on the edge that samples the first bit and to 0 on the completion edge.
- overrun goes to 1 on the completion edge of the dropped word.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- DFF_DESER_PARITY_EN defined:
  - One extra bit follows each word and is treated as an even-parity bit over the WIDTH data bits.
  - parity_err is registered together with word_out: 1 if the XOR of all data bits and the parity bit is 1.
  - The word is delivered regardless of the parity result.
  - parity_err updates only when a word loads. Dropped words do not update it.
- DFF_DESER_PARITY_EN undefined: no PARITY state, no parity_err port, and a word completes after WIDTH bits.

## Structure
- Shared package dff_deser_pkg holds:
  - the collect-FSM state encodings as localparams: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2;
  - the counter-width function.
- Sub-module dff_deser_shift contains the shift register, bit counter and done pulse. It is parameterised by WIDTH and MSB_FIRST.
- The top level contains the FSM, holding register, handshake and flags.

## Test plan
- Reset: hold clr=0 with bit_valid=1 and toggling bits -> word_out=0, word_valid=0, overrun=0, busy=0 throughout.
- Back-to-back words: WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, word_ready=1 -> word_out=8'hA5 with word_valid high for exactly one cycle, starting at the 8th sampling edge.
- Gapped input: the same bits with bit_valid low on alternate cycles -> word_out=8'hA5. busy stays 1 across the gaps.
- Overrun: word_ready=0, send 8'hA5 then 8'h3C -> word_out stays A5 and overrun=1 after the 16th bit. Then raise word_ready -> word_valid falls after one edge and overrun stays 1.
- Mid-word reset: send 4 bits, pulse clr low, then send 8'h0F -> the first word seen is 8'h0F.
- With DFF_DESER_PARITY_EN: send A5 followed by parity bit 0 -> parity_err=0. Send A5 followed by parity bit 1 -> parity_err=1, and word_out=A5 in both cases.
